// File: rtl/vending_machine.sv
// Coin-credit vending FSM: accumulates nickel/dime/quarter credit in 5-cent states.
// Latency: coins sampled at an edge are reflected in state and valid right after that edge.
// Backpressure: none; coins are accepted every cycle, and valid is a one-cycle pulse per 100 cents.
//
// Ports:
//   clk      rising-edge clock for all state
//   reset_n  synchronous active-low reset (returns credit to 0, clears valid)
//   nickel   5-cent coin present this cycle (level sampled)
//   dime     10-cent coin present this cycle (level sampled)
//   quarter  25-cent coin present this cycle (level sampled)
//   valid    dispense light; high exactly while stored credit is >= 100 cents
module vending_machine (
  input  logic clk,
  input  logic reset_n,
  input  logic nickel,
  input  logic dime,
  input  logic quarter,
  output logic valid
);

  // One state per 5-cent credit value; the encoding equals credit / 5.
  typedef enum logic [4:0] {
    CR0,   CR5,   CR10,  CR15,  CR20,  CR25,  CR30,  CR35,
    CR40,  CR45,  CR50,  CR55,  CR60,  CR65,  CR70,  CR75,
    CR80,  CR85,  CR90,  CR95,  CR100, CR105, CR110, CR115,
    CR120, CR125, CR130, CR135
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] coin_units;   // this cycle's coins in 5-cent units, 0..8
  logic [4:0] base_units;   // credit kept after a possible dispense, 0..19
  logic [4:0] next_units;   // 0..27, always fits a legal state

  always_comb begin
    coin_units = {3'b000, nickel} + {2'b00, dime, 1'b0} + (quarter ? 4'd5 : 4'd0);
    // A dispense cycle spends 100 cents but keeps the excess and this cycle's coins.
    base_units = (state >= CR100) ? (5'(state) - 5'd20) : 5'(state);
    next_units = base_units + {1'b0, coin_units};
    if (state > CR135) begin
      state_next = CR0;     // encodings 28..31 are unreachable; recover to empty
    end else begin
      state_next = state_t'(next_units);
    end
  end

  // valid is registered from the next state so it is a pure flop output that
  // always matches the current state, with no path from the coin inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CR0;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      valid <= (state_next >= CR100);
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic nickel = 1'b0;
  logic dime = 1'b0;
  logic quarter = 1'b0;
  logic valid;

  always #5 clk = ~clk;

  vending_machine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .nickel  (nickel),
    .dime    (dime),
    .quarter (quarter),
    .valid   (valid)
  );

  typedef struct {
    int    credit;
    bit    vld;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Directed vectors: coins as {q,d,n} and hand-computed credit after each edge.
  logic [2:0] v23 [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0};
  int         c23 [10] = '{0, 5, 15, 30, 55, 85, 120, 60, 60, 60};
  logic [2:0] v24 [5]  = '{3'd7, 3'd7, 3'd3, 3'd7, 3'd7};
  int         c24 [5]  = '{40, 80, 95, 135, 75};
  logic [2:0] v25 [5]  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
  int         c25 [5]  = '{25, 50, 75, 100, 0};
  logic [2:0] v26 [4]  = '{3'd4, 3'd4, 3'd4, 3'd2};
  int         c26 [4]  = '{25, 50, 75, 85};

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic step(input bit rn, input logic [2:0] qdn, input int exp_c, input string tag);
    exp_t e;
    @(negedge clk);
    reset_n = rn;
    {quarter, dime, nickel} = qdn;
    e.credit = exp_c;
    e.vld    = (exp_c >= 100);
    e.tag    = tag;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one sample per cycle, #1 after the edge; pops and compares.
  bit prev_v = 1'b0;
  initial begin
    exp_t e;
    int   act_c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_c = 5 * int'(dut.state);
        checks++;
        if (valid !== e.vld) begin
          failures++;
          $display("FAIL %s valid: got %b expected %b", e.tag, valid, e.vld);
        end
        checks++;
        if (act_c != e.credit) begin
          failures++;
          $display("FAIL %s credit: got %0d expected %0d", e.tag, act_c, e.credit);
        end
        checks++;
        if (act_c > 135) begin
          failures++;
          $display("FAIL %s credit_max: got %0d expected <= 135", e.tag, act_c);
        end
        checks++;
        if (prev_v && (valid === 1'b1)) begin
          failures++;
          $display("FAIL %s valid_twice: got 1 in consecutive cycles expected single pulse", e.tag);
        end
      end
      prev_v = (valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    step(1'b0, 3'd0, 0, "reset");

    for (int i = 0; i < 10; i++) step(1'b1, v23[i], c23[i], "coin_sweep");

    step(1'b0, 3'd0, 0, "reset");
    for (int i = 0; i < 5; i++) step(1'b1, v24[i], c24[i], "max_credit_carry");

    step(1'b0, 3'd0, 0, "reset");
    for (int i = 0; i < 5; i++) step(1'b1, v25[i], c25[i], "exact_100");

    step(1'b0, 3'd0, 0, "reset");
    for (int i = 0; i < 4; i++) step(1'b1, v26[i], c26[i], "reach_85");
    step(1'b0, 3'd7, 0, "reset_over_coins");
    step(1'b1, 3'd0, 0, "after_reset_85");

    step(1'b0, 3'd0, 0, "reset");
    for (int i = 0; i < 4; i++) step(1'b1, 3'd4, 25 * (i + 1), "reach_100");
    step(1'b0, 3'd7, 0, "reset_in_dispense");
    step(1'b1, 3'd0, 0, "after_reset_dispense");

    step(1'b0, 3'd0, 0, "reset");
    for (int i = 1; i <= 20; i++) step(1'b1, 3'd1, 5 * i, "nickels");
    step(1'b1, 3'd0, 0, "nickels_spend");

    step(1'b0, 3'd0, 0, "reset");
    c = 0;
    for (int i = 0; i < 30; i++) begin
      c = ((c >= 100) ? c - 100 : c) + 40;
      step(1'b1, 3'd7, c, "continuous_111");
    end

    @(negedge clk);
    {quarter, dime, nickel} = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the clock port is named clk and the reset port is named reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 nickel  input  1  high = a 5-cent coin is inserted this cycle; sampled on the rising edge of clk.
REQ-005 dime  input  1  high = a 10-cent coin is inserted this cycle; sampled on the rising edge of clk.
REQ-006 quarter  input  1  high = a 25-cent coin is inserted this cycle; sampled on the rising edge of clk.
REQ-007 valid  output  1  dispense/green light; high for exactly the cycles in which the stored credit is at least 100 cents.
REQ-008 The block SHALL have no other ports; coin inputs are level-sampled with no edge detection or debounce.

Function
REQ-009 The block SHALL hold an 8-bit unsigned credit register C in cents; C is always a multiple of 5 and never exceeds 135.
REQ-010 Each cycle the coin sum S = 5*nickel + 10*dime + 25*quarter; any combination may be asserted together, and S ranges from 0 to 40.
REQ-011 C SHALL be implemented as an explicit state machine with 28 states, CR0, CR5, ..., CR135, one per 5-cent credit value.
REQ-012 valid SHALL be a Moore output: valid = 1 exactly when the state is CR100 or above, with no combinational path from any coin input to valid.
REQ-013 If C < 100, then C_next = C + S.
REQ-014 If C >= 100 (dispense cycle), then C_next = C - 100 + S; the excess credit and the coins inserted in the dispense cycle are carried forward, never discarded.
REQ-015 From REQ-013 and REQ-014, the maximum credit is 95 + 40 = 135, and after a dispense C_next is at most 35 + 40 = 75; valid therefore never stays high for two consecutive cycles.
REQ-016 Credit reaching exactly 100 SHALL assert valid on the following cycle, the same as credit above 100.
REQ-017 No overflow or wrap-around SHALL be possible; the implementation SHALL NOT saturate or truncate within the 0..135 range.
REQ-018 Unused or unreachable state encodings SHALL return to CR0 on the next clock edge.

Reset
REQ-019 When reset_n = 0 at a rising edge, C SHALL become 0 (CR0) and valid SHALL be 0 from the next cycle.
REQ-020 Reset SHALL override coins: coins present in a reset cycle are discarded.
REQ-021 Reset in a dispense cycle SHALL discard both the carried credit and that cycle's coins.
REQ-022 Before the first reset, the state is undefined.

Verification
REQ-023 Reset, then coin vectors {q,d,n} = 0,1,2,...,7, one per cycle, then 000 for two cycles -> C sequence 0,5,15,30,55,85,120,60,60,60; valid = 1 only in the cycle where C = 120.
REQ-024 After reset, apply 111, 111, 011, 111, 111 -> C = 40, 80, 95, 135, 75; valid = 1 only in the cycle where C = 135; the coins from that cycle are carried into 75.
REQ-025 After reset, apply 100 four times -> C = 25, 50, 75, 100; then 000 -> C = 0 with valid = 1 during the C = 100 cycle.
REQ-026 With C = 85, assert reset_n = 0 together with coins 111 -> C = 0 and valid = 0, with no dispense.
REQ-027 After reset, apply 001 twenty times -> C increases by 5 each cycle to 100; valid first goes high in the cycle after the 20th nickel is sampled.
REQ-028 Continuously apply coins 111 -> valid pulses; check that valid is never high in two consecutive cycles and that C never exceeds 135.
